// File: rtl/sdr_receive.sv
// Protocol-2 UDP ingress parser: demultiplexes payload bytes by destination port,
// raises discovery/erase requests, updates run/PTT, and forwards program and Tx I/Q bytes.
module sdr_receive #(
    parameter logic [15:0] GENERAL_PORT = 16'd1024,
    parameter logic [15:0] HP_PORT      = 16'd1027,
    parameter logic [15:0] TXIQ_PORT    = 16'd1029,
    parameter logic [15:0] PROG_BYTES   = 16'd256,
    parameter logic [15:0] IQ_BYTES     = 16'd1440
) (
    input  logic        rx_clock,
    input  logic        reset,
    input  logic        udp_rx_active,
    input  logic [7:0]  udp_rx_data,
    input  logic [15:0] to_port,
    input  logic        discovery_ACK,
    input  logic        erase_ACK,
    input  logic        tx_fifo_full,
    output logic        discovery,
    output logic        erase,
    output logic        run,
    output logic        PTT,
    output logic [31:0] sequence_number,
    output logic [7:0]  prog_data,
    output logic        prog_wrreq,
    output logic        prog_block,
    output logic [7:0]  tx_fifo_data,
    output logic        tx_fifo_wrreq,
    output logic        tx_overflow,
    output logic [15:0] hp_seq_err
);

    typedef enum logic [2:0] {IDLE, GEN, PROG, HP, TXIQ, DISCARD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_byte_no;
    logic [31:0] r_seq_tmp;
    logic [31:0] r_hp_expected;
    logic [7:0]  r_cmd;
    logic [15:0] r_prog_cnt;
    logic [1:0]  r_hp_ctrl;
    logic        r_hp_got;
    logic        r_hp_first;
    logic        r_active_d;
    logic [15:0] w_idx;
    logic        w_start;
    logic        w_end;
    logic        w_take;
    logic        w_disc_set;
    logic        w_erase_set;

    // Packet framing: start on a rising udp_rx_active, end when it drops; index of current byte
    always_comb begin
        w_start     = (r_state == IDLE) && udp_rx_active && !r_active_d;
        w_end       = (r_state != IDLE) && !udp_rx_active;
        w_take      = w_start || ((r_state != IDLE) && udp_rx_active);
        w_idx       = (r_state == IDLE) ? 16'd0 : r_byte_no;
        w_disc_set  = (r_state == GEN) && w_end && (r_cmd == 8'h02);
        w_erase_set = (r_state == GEN) && w_end && (r_cmd == 8'h03);
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (to_port == GENERAL_PORT)   w_next = GEN;
                    else if (to_port == HP_PORT)   w_next = HP;
                    else if (to_port == TXIQ_PORT) w_next = TXIQ;
                    else                           w_next = DISCARD;
                end
            end
            GEN: begin
                if (!udp_rx_active) begin
                    w_next = IDLE;
                end else if (w_idx == 16'd4) begin
                    if (udp_rx_data == 8'h04)
                        w_next = PROG;
                    else if (udp_rx_data != 8'h02 && udp_rx_data != 8'h03)
                        w_next = DISCARD;
                end
            end
            default: begin
                if (!udp_rx_active) w_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge rx_clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Byte counting, header capture, per-port actions and registered outputs
    always_ff @(posedge rx_clock) begin
        if (reset) begin
            r_byte_no       <= 16'd0;
            r_seq_tmp       <= 32'd0;
            r_hp_expected   <= 32'd0;
            r_cmd           <= 8'd0;
            r_prog_cnt      <= 16'd0;
            r_hp_ctrl       <= 2'd0;
            r_hp_got        <= 1'b0;
            r_hp_first      <= 1'b1;
            // Treat the line as busy so a packet in flight at reset is skipped
            r_active_d      <= 1'b1;
            discovery       <= 1'b0;
            erase           <= 1'b0;
            run             <= 1'b0;
            PTT             <= 1'b0;
            sequence_number <= 32'd0;
            prog_data       <= 8'd0;
            prog_wrreq      <= 1'b0;
            prog_block      <= 1'b0;
            tx_fifo_data    <= 8'd0;
            tx_fifo_wrreq   <= 1'b0;
            tx_overflow     <= 1'b0;
            hp_seq_err      <= 16'd0;
        end else begin
            r_active_d    <= udp_rx_active;
            prog_wrreq    <= 1'b0;
            prog_block    <= 1'b0;
            tx_fifo_wrreq <= 1'b0;

            // A same-cycle new request beats the ACK
            discovery <= w_disc_set  | (discovery & ~discovery_ACK);
            erase     <= w_erase_set | (erase & ~erase_ACK);

            if (r_state == IDLE)
                r_byte_no <= w_start ? 16'd1 : 16'd0;
            else if (udp_rx_active && r_byte_no != 16'hFFFF)
                r_byte_no <= r_byte_no + 16'd1;

            if (w_take && w_idx < 16'd4)
                r_seq_tmp <= {r_seq_tmp[23:0], udp_rx_data};

            case (r_state)
                IDLE: begin
                    r_cmd      <= 8'd0;
                    r_prog_cnt <= 16'd0;
                    r_hp_got   <= 1'b0;
                end
                GEN: begin
                    if (udp_rx_active && w_idx == 16'd4) begin
                        r_cmd <= udp_rx_data;
                        if (udp_rx_data == 8'h04) sequence_number <= r_seq_tmp;
                    end
                end
                PROG: begin
                    if (udp_rx_active && w_idx >= 16'd5 && w_idx <= PROG_BYTES + 16'd4) begin
                        prog_data  <= udp_rx_data;
                        prog_wrreq <= 1'b1;
                        r_prog_cnt <= r_prog_cnt + 16'd1;
                    end
                    if (w_end && r_prog_cnt == PROG_BYTES) prog_block <= 1'b1;
                end
                HP: begin
                    if (udp_rx_active && w_idx == 16'd4) begin
                        r_hp_ctrl <= udp_rx_data[1:0];
                        r_hp_got  <= 1'b1;
                    end
                    if (w_end) begin
                        if (r_hp_got) begin
                            run <= r_hp_ctrl[0];
                            PTT <= r_hp_ctrl[1];
                        end
                        // Sequence check needs the full 4-byte header
                        if (r_byte_no >= 16'd4) begin
                            if (!r_hp_first && r_seq_tmp != r_hp_expected && hp_seq_err != 16'hFFFF)
                                hp_seq_err <= hp_seq_err + 16'd1;
                            r_hp_expected <= r_seq_tmp + 32'd1;
                            r_hp_first    <= 1'b0;
                        end
                    end
                end
                TXIQ: begin
                    if (udp_rx_active && w_idx >= 16'd4 && w_idx <= IQ_BYTES + 16'd3) begin
                        if (tx_fifo_full) begin
                            tx_overflow <= 1'b1;
                        end else begin
                            tx_fifo_data  <= udp_rx_data;
                            tx_fifo_wrreq <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_receive.sv
// Directed bench for sdr_receive: expected FIFO bytes queued at stimulus time,
// checked by a negedge monitor; flags and counters checked against hand values.
module tb_sdr_receive;

    logic        rx_clock = 1'b0;
    logic        reset;
    logic        udp_rx_active;
    logic [7:0]  udp_rx_data;
    logic [15:0] to_port;
    logic        discovery_ACK;
    logic        erase_ACK;
    logic        tx_fifo_full;
    logic        discovery;
    logic        erase;
    logic        run;
    logic        PTT;
    logic [31:0] sequence_number;
    logic [7:0]  prog_data;
    logic        prog_wrreq;
    logic        prog_block;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_wrreq;
    logic        tx_overflow;
    logic [15:0] hp_seq_err;

    sdr_receive dut (
        .rx_clock(rx_clock), .reset(reset), .udp_rx_active(udp_rx_active),
        .udp_rx_data(udp_rx_data), .to_port(to_port), .discovery_ACK(discovery_ACK),
        .erase_ACK(erase_ACK), .tx_fifo_full(tx_fifo_full), .discovery(discovery),
        .erase(erase), .run(run), .PTT(PTT), .sequence_number(sequence_number),
        .prog_data(prog_data), .prog_wrreq(prog_wrreq), .prog_block(prog_block),
        .tx_fifo_data(tx_fifo_data), .tx_fifo_wrreq(tx_fifo_wrreq),
        .tx_overflow(tx_overflow), .hp_seq_err(hp_seq_err)
    );

    always #5 rx_clock = ~rx_clock;

    int errors = 0;
    int checks = 0;
    int blocks_seen = 0;
    int prog_writes = 0;
    int tx_writes = 0;
    int full_lo = -1;
    int full_hi = -1;
    logic [7:0] pkt[$];
    logic [7:0] prog_q[$];
    logic [7:0] tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge rx_clock); #1; end
    endtask

    task automatic hdr(input logic [31:0] seq);
        pkt.delete();
        pkt.push_back(seq[31:24]);
        pkt.push_back(seq[23:16]);
        pkt.push_back(seq[15:8]);
        pkt.push_back(seq[7:0]);
    endtask

    // Drive pkt back to back, queue expected writes, end with one low cycle
    task automatic send(input logic [15:0] port, input bit ack_end);
        for (int i = 0; i < pkt.size(); i++) begin
            udp_rx_active = 1'b1;
            udp_rx_data   = pkt[i];
            to_port       = port;
            tx_fifo_full  = (i >= full_lo && i < full_hi);
            if (port == 16'd1024 && pkt.size() >= 5 && pkt[4] == 8'h04 && i >= 5 && i <= 260)
                prog_q.push_back(pkt[i]);
            if (port == 16'd1029 && i >= 4 && i <= 1443 && !tx_fifo_full)
                tx_q.push_back(pkt[i]);
            @(posedge rx_clock); #1;
        end
        udp_rx_active = 1'b0;
        tx_fifo_full  = 1'b0;
        if (ack_end) erase_ACK = 1'b1;
        @(posedge rx_clock); #1;
    endtask

    initial begin
        reset = 1'b1; udp_rx_active = 1'b0; udp_rx_data = 8'd0; to_port = 16'd0;
        discovery_ACK = 1'b0; erase_ACK = 1'b0; tx_fifo_full = 1'b0;

        fork
            forever begin
                @(negedge rx_clock);
                if (prog_wrreq) begin
                    prog_writes++;
                    if (prog_q.size() == 0) chk("prog_wrreq_unexpected", 32'd1, 32'd0);
                    else chk("prog_data", 32'(prog_data), 32'(prog_q.pop_front()));
                end
                if (tx_fifo_wrreq) begin
                    tx_writes++;
                    if (tx_q.size() == 0) chk("tx_wrreq_unexpected", 32'd1, 32'd0);
                    else chk("tx_fifo_data", 32'(tx_fifo_data), 32'(tx_q.pop_front()));
                end
                if (prog_block) blocks_seen++;
            end
        join_none

        idle(3);
        reset = 1'b0;
        idle(2);
        chk("rst_discovery", 32'(discovery), 32'd0);
        chk("rst_erase", 32'(erase), 32'd0);
        chk("rst_run_ptt", 32'({run, PTT}), 32'd0);
        chk("rst_seqnum", sequence_number, 32'd0);
        chk("rst_strobes", 32'({prog_wrreq, prog_block, tx_fifo_wrreq}), 32'd0);
        chk("rst_overflow", 32'(tx_overflow), 32'd0);
        chk("rst_hp_err", 32'(hp_seq_err), 32'd0);

        // Discovery request held until ACK
        hdr(32'h5); pkt.push_back(8'h02);
        send(16'd1024, 1'b0);
        idle(3);
        chk("disc_held", 32'(discovery), 32'd1);
        chk("disc_erase_idle", 32'(erase), 32'd0);
        discovery_ACK = 1'b1;
        chk("disc_before_ack_edge", 32'(discovery), 32'd1);
        idle(1);
        discovery_ACK = 1'b0;
        chk("disc_cleared", 32'(discovery), 32'd0);
        chk("disc_run_unchanged", 32'(run), 32'd0);

        // Erase request; a new request coinciding with ACK keeps the flag
        hdr(32'h6); pkt.push_back(8'h03);
        send(16'd1024, 1'b0);
        chk("erase_set", 32'(erase), 32'd1);
        send(16'd1024, 1'b1);
        erase_ACK = 1'b0;
        chk("erase_req_beats_ack", 32'(erase), 32'd1);
        erase_ACK = 1'b1;
        idle(1);
        erase_ACK = 1'b0;
        chk("erase_cleared", 32'(erase), 32'd0);

        // Full program block (plus two surplus bytes), then discovery right behind it
        hdr(32'h10); pkt.push_back(8'h04);
        for (int i = 0; i < 256; i++) pkt.push_back(8'(i));
        pkt.push_back(8'hAA); pkt.push_back(8'hBB);
        send(16'd1024, 1'b0);
        hdr(32'h7); pkt.push_back(8'h02);
        send(16'd1024, 1'b0);
        idle(1);
        chk("prog_seqnum", sequence_number, 32'h10);
        chk("prog_writes_256", 32'(prog_writes), 32'd256);
        chk("prog_block_256", 32'(blocks_seen), 32'd1);
        chk("disc_after_prog", 32'(discovery), 32'd1);
        discovery_ACK = 1'b1;
        idle(1);
        discovery_ACK = 1'b0;

        // Short program packet: writes but no block pulse
        hdr(32'h11); pkt.push_back(8'h04);
        for (int i = 0; i < 200; i++) pkt.push_back(8'(i + 7));
        send(16'd1024, 1'b0);
        idle(2);
        chk("prog_writes_200", 32'(prog_writes), 32'd456);
        chk("prog_no_block", 32'(blocks_seen), 32'd1);
        chk("prog_seqnum2", sequence_number, 32'h11);

        // High-priority packets: seq 0,1,3 then 4 with run/PTT cleared
        hdr(32'd0); pkt.push_back(8'h03); send(16'd1027, 1'b0);
        hdr(32'd1); pkt.push_back(8'h03); send(16'd1027, 1'b0);
        chk("hp_no_err_yet", 32'(hp_seq_err), 32'd0);
        hdr(32'd3); pkt.push_back(8'h03); send(16'd1027, 1'b0);
        chk("hp_run", 32'(run), 32'd1);
        chk("hp_ptt", 32'(PTT), 32'd1);
        chk("hp_err_1", 32'(hp_seq_err), 32'd1);
        hdr(32'd4); pkt.push_back(8'h00); send(16'd1027, 1'b0);
        chk("hp_run_ptt_off", 32'({run, PTT}), 32'd0);
        chk("hp_err_still_1", 32'(hp_seq_err), 32'd1);

        // Tx I/Q packet with FIFO full for 10 bytes
        hdr(32'h100);
        for (int i = 0; i < 1440; i++) pkt.push_back(8'(i * 3));
        full_lo = 500; full_hi = 510;
        send(16'd1029, 1'b0);
        full_lo = -1; full_hi = -1;
        idle(1);
        chk("txiq_writes", 32'(tx_writes), 32'd1430);
        chk("txiq_overflow", 32'(tx_overflow), 32'd1);

        // Foreign port, unknown command and runt packet change nothing
        hdr(32'h9); pkt.push_back(8'h02); pkt.push_back(8'h55); send(16'd1030, 1'b0);
        hdr(32'h9); pkt.push_back(8'h07); pkt.push_back(8'h01); send(16'd1024, 1'b0);
        pkt.delete(); pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h00);
        send(16'd1024, 1'b0);
        idle(2);
        chk("quiet_flags", 32'({discovery, erase, run, PTT}), 32'd0);
        chk("quiet_seqnum", sequence_number, 32'h11);
        chk("quiet_hp_err", 32'(hp_seq_err), 32'd1);
        chk("overflow_sticky", 32'(tx_overflow), 32'd1);
        chk("quiet_writes", 32'(prog_writes + tx_writes), 32'd1886);

        // Reset in the middle of a Tx I/Q packet
        hdr(32'h200);
        for (int i = 0; i < 116; i++) pkt.push_back(8'(i + 1));
        for (int i = 0; i < 100; i++) begin
            udp_rx_active = 1'b1; udp_rx_data = pkt[i]; to_port = 16'd1029;
            if (i >= 4) tx_q.push_back(pkt[i]);
            @(posedge rx_clock); #1;
        end
        reset = 1'b1;
        udp_rx_data = pkt[100];
        @(posedge rx_clock); #1;
        chk("rst_mid_wrreq", 32'(tx_fifo_wrreq), 32'd0);
        chk("rst_mid_overflow", 32'(tx_overflow), 32'd0);
        udp_rx_data = pkt[101];
        @(posedge rx_clock); #1;
        reset = 1'b0;
        for (int i = 102; i < 110; i++) begin
            udp_rx_data = pkt[i];
            @(posedge rx_clock); #1;
        end
        udp_rx_active = 1'b0;
        idle(1);
        hdr(32'h1); pkt.push_back(8'h02);
        send(16'd1024, 1'b0);
        chk("post_rst_discovery", 32'(discovery), 32'd1);
        chk("post_rst_hp_err", 32'(hp_seq_err), 32'd0);

        idle(5);
        chk("prog_q_drained", 32'(prog_q.size()), 32'd0);
        chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
        chk("tx_writes_total", 32'(tx_writes), 32'd1526);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
